rx_frame_buffer: RTL

Receive-side buffer that sits directly downstream of the frame receiver. It captures each completed WIDTH-bit word, presented by the receiver as a one-cycle `ready` pulse alongside `data`, into a DEPTH-entry first-word-fall-through FIFO. It presents the words to the consumer over a valid/ready handshake. Overflow is reported as a sticky flag plus a saturating drop counter, so a slow consumer never stalls the serial link.

---
 rtl/rx_frame_buffer.sv | 94 +++++++++
 1 files changed

// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: first-word-fall-through FIFO behind the frame receiver.
// Each one-cycle frameReady pulse is captured into the FIFO, and the words are
// presented to the consumer over a valid/ready handshake. A frame that arrives
// while the FIFO is full, with no pop in the same cycle, is dropped. The drop
// sets a sticky overflow flag and bumps a saturating drop counter, so the
// serial link is never stalled.
module rx_frame_buffer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      frameData,
  input  logic                  frameReady,
  output logic [WIDTH-1:0]      outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clearOverflow,
  output logic [7:0]            droppedCount
);

  localparam int unsigned           DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a frame
  // when the consumer is reading.
  always_comb begin
    full = (count == FULL_COUNT);
    pop  = outValid && outReady;
    push = frameReady && (!full || pop);
    drop = frameReady && full && !pop;
  end

  assign outValid = (count != '0);
  assign outData  = mem[rdPtr];

  // Payload storage is deliberately left without a reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wrPtr] <= frameData;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Drop reporting: a drop in the same cycle as a clear takes precedence and
  // restarts the counter at one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow     <= 1'b0;
      droppedCount <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clearOverflow) begin
        droppedCount <= 8'd1;
      end else if (droppedCount != 8'hFF) begin
        droppedCount <= droppedCount + 8'd1;
      end
    end else if (clearOverflow) begin
      overflow     <= 1'b0;
      droppedCount <= '0;
    end
  end

endmodule
